// File: rtl/ace_snoop_initiator.sv
// Purpose : interconnect-side ACE snoop master; issues one AC snoop, collects CR + optional CD line.
// Latency : i_start to o_done is 4 cycles minimum (acready, crvalid high, no data transfer).
// Backpress: AC payload held until acready; crready/cdready held until their final handshake or timeout.
// Ports   : i_start/i_acaddr/i_acsnoop/i_acprot/i_timeout request from the register file;
//           ac*/cr*/cd* ACE snoop channels; o_* results back to the register file.
module ace_snoop_initiator #(
   parameter int C_ACE_DATA_WIDTH = 128,
   parameter int C_ACE_ADDR_WIDTH = 44,
   parameter int C_CD_BEATS       = 4,
   parameter int C_CNT_WIDTH      = 16
) (
   input  logic                                   ace_aclk,
   input  logic                                   ace_aresetn,
   input  logic                                   i_start,
   input  logic [C_ACE_ADDR_WIDTH-1:0]            i_acaddr,
   input  logic [3:0]                             i_acsnoop,
   input  logic [2:0]                             i_acprot,
   input  logic [C_CNT_WIDTH-1:0]                 i_timeout,
   output logic                                   acvalid,
   input  logic                                   acready,
   output logic [C_ACE_ADDR_WIDTH-1:0]            acaddr,
   output logic [3:0]                             acsnoop,
   output logic [2:0]                             acprot,
   input  logic                                   crvalid,
   output logic                                   crready,
   input  logic [4:0]                             crresp,
   input  logic                                   cdvalid,
   output logic                                   cdready,
   input  logic [C_ACE_DATA_WIDTH-1:0]            cddata,
   input  logic                                   cdlast,
   output logic                                   o_busy,
   output logic                                   o_done,
   output logic [4:0]                             o_crresp,
   output logic [C_ACE_DATA_WIDTH*C_CD_BEATS-1:0] o_cdata,
   output logic [C_CNT_WIDTH-1:0]                 o_latency,
   output logic                                   o_timeout_err,
   output logic                                   o_proto_err
);

   // Beat counter has headroom beyond one line so overruns remain visible.
   localparam int                   BW         = $clog2(C_CD_BEATS) + 2;
   localparam logic [BW-1:0]        LINE_BEATS = BW'(C_CD_BEATS);
   localparam logic [BW-1:0]        LAST_IDX   = BW'(C_CD_BEATS - 1);
   localparam logic [C_CNT_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {S_IDLE, S_AC, S_RESP, S_DONE} state_t;
   state_t state, state_nxt;

   logic                   cr_seen, last_seen, ovf;
   logic [BW-1:0]          beat_cnt, last_idx;
   logic [C_CNT_WIDTH-1:0] cyc_cnt;

   logic                   ac_hs, cr_hs, cd_hs;
   logic                   cr_now, last_now, dt_now, ovf_now;
   logic [BW-1:0]          beats_now, last_idx_now;
   logic [C_CNT_WIDTH-1:0] cyc_inc, lat_inc;
   logic                   exit_ok, tmo, proto_now;

   assign ac_hs  = acvalid & acready;
   assign cr_hs  = crvalid & crready;
   assign cd_hs  = cdvalid & cdready;
   assign o_busy = (state != S_IDLE);

   // "Now" views fold in this cycle's handshakes so a CR and the final CD
   // beat arriving together complete in the same cycle.
   assign cr_now       = cr_seen | cr_hs;
   assign last_now     = last_seen | (cd_hs & cdlast);
   assign dt_now       = cr_hs ? crresp[0] : o_crresp[0];
   assign ovf_now      = ovf | (cd_hs & (beat_cnt >= LINE_BEATS));
   assign last_idx_now = (cd_hs & cdlast) ? beat_cnt : last_idx;
   assign beats_now    = (cd_hs && beat_cnt != '1) ? beat_cnt + BW'(1) : beat_cnt;
   assign cyc_inc      = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
   assign lat_inc      = (o_latency == CNT_MAX) ? o_latency : o_latency + 1'b1;

   assign exit_ok   = cr_now & (~dt_now | last_now);
   assign tmo       = (i_timeout != '0) & (cyc_inc == i_timeout) & ~exit_ok;
   assign proto_now = dt_now ? ((beats_now != LINE_BEATS) | ~last_now |
                                (last_idx_now != LAST_IDX) | ovf_now)
                             : (beats_now != '0);

   always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
      if (!ace_aresetn) state <= S_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (i_start)          state_nxt = S_AC;
         S_AC:    if (ac_hs)            state_nxt = S_RESP;
         S_RESP:  if (exit_ok || tmo)   state_nxt = S_DONE;
         S_DONE:                        state_nxt = S_IDLE;
         default:                       state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
      if (!ace_aresetn) begin
         acvalid       <= 1'b0;
         acaddr        <= '0;
         acsnoop       <= '0;
         acprot        <= '0;
         crready       <= 1'b0;
         cdready       <= 1'b0;
         o_done        <= 1'b0;
         o_crresp      <= '0;
         o_cdata       <= '0;
         o_latency     <= '0;
         o_timeout_err <= 1'b0;
         o_proto_err   <= 1'b0;
         cr_seen       <= 1'b0;
         last_seen     <= 1'b0;
         ovf           <= 1'b0;
         beat_cnt      <= '0;
         last_idx      <= '0;
         cyc_cnt       <= '0;
      end else begin
         // Registered pulse: visible the cycle after DONE, when results are final.
         o_done <= (state == S_DONE);
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  acaddr        <= i_acaddr;
                  acsnoop       <= i_acsnoop;
                  acprot        <= i_acprot;
                  acvalid       <= 1'b1;
                  o_crresp      <= '0;
                  o_cdata       <= '0;
                  o_latency     <= '0;
                  o_timeout_err <= 1'b0;
                  o_proto_err   <= 1'b0;
                  cr_seen       <= 1'b0;
                  last_seen     <= 1'b0;
                  ovf           <= 1'b0;
                  beat_cnt      <= '0;
                  last_idx      <= '0;
                  cyc_cnt       <= '0;
               end
            end
            S_AC: begin
               if (ac_hs) begin
                  acvalid   <= 1'b0;
                  crready   <= 1'b1;
                  cdready   <= 1'b1;
                  o_latency <= '0;
                  cyc_cnt   <= '0;
               end
            end
            S_RESP: begin
               cyc_cnt <= cyc_inc;
               // Counts the CR handshake cycle itself, then freezes.
               if (!cr_seen) o_latency <= lat_inc;
               if (cr_hs) begin
                  cr_seen  <= 1'b1;
                  crready  <= 1'b0;
                  o_crresp <= crresp;
               end
               if (cd_hs) begin
                  for (int n = 0; n < C_CD_BEATS; n++)
                     if (beat_cnt == BW'(n))
                        o_cdata[n*C_ACE_DATA_WIDTH +: C_ACE_DATA_WIDTH] <= cddata;
                  if (beat_cnt >= LINE_BEATS) ovf <= 1'b1;
                  beat_cnt <= beats_now;
                  if (cdlast) begin
                     last_seen <= 1'b1;
                     last_idx  <= beat_cnt;
                     cdready   <= 1'b0;
                  end
               end
               if (exit_ok) begin
                  crready     <= 1'b0;
                  cdready     <= 1'b0;
                  o_proto_err <= proto_now;
               end else if (tmo) begin
                  // Response type may be unknown here; only an overrun is reportable.
                  crready       <= 1'b0;
                  cdready       <= 1'b0;
                  o_timeout_err <= 1'b1;
                  o_proto_err   <= ovf_now;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Purpose : self-checking bench for ace_snoop_initiator; directed cases then randomized snoops.
// Latency : n/a (testbench).
// Backpress: drives acready with random delay; CR/CD responder driven from a per-snoop schedule.
module tb_ace_snoop_initiator;

   localparam int DW  = 128;
   localparam int AW  = 44;
   localparam int NB  = 4;
   localparam int CW  = 16;
   localparam int LW  = DW * NB;
   localparam int INF = 100000;

   logic          ace_aclk = 1'b0;
   logic          ace_aresetn = 1'b0;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_acaddr = '0;
   logic [3:0]    i_acsnoop = '0;
   logic [2:0]    i_acprot = '0;
   logic [CW-1:0] i_timeout = '0;
   logic          acvalid, acready = 1'b0;
   logic [AW-1:0] acaddr;
   logic [3:0]    acsnoop;
   logic [2:0]    acprot;
   logic          crvalid = 1'b0, crready;
   logic [4:0]    crresp = '0;
   logic          cdvalid = 1'b0, cdready;
   logic [DW-1:0] cddata = '0;
   logic          cdlast = 1'b0;
   logic          o_busy, o_done;
   logic [4:0]    o_crresp;
   logic [LW-1:0] o_cdata;
   logic [CW-1:0] o_latency;
   logic          o_timeout_err, o_proto_err;

   ace_snoop_initiator #(
      .C_ACE_DATA_WIDTH(DW), .C_ACE_ADDR_WIDTH(AW), .C_CD_BEATS(NB), .C_CNT_WIDTH(CW)
   ) dut (
      .ace_aclk(ace_aclk), .ace_aresetn(ace_aresetn), .i_start(i_start),
      .i_acaddr(i_acaddr), .i_acsnoop(i_acsnoop), .i_acprot(i_acprot), .i_timeout(i_timeout),
      .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop), .acprot(acprot),
      .crvalid(crvalid), .crready(crready), .crresp(crresp),
      .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
      .o_busy(o_busy), .o_done(o_done), .o_crresp(o_crresp), .o_cdata(o_cdata),
      .o_latency(o_latency), .o_timeout_err(o_timeout_err), .o_proto_err(o_proto_err)
   );

   always #5 ace_aclk = ~ace_aclk;

   int n_chk = 0;
   int n_err = 0;
   int cyc_n = 0;

   // Scenario for one snoop: CR on RESP cycle sc_k (0 = never), CD beat i on RESP cycle sc_cyc[i].
   int            sc_k, sc_nb, sc_acd;
   int            sc_cyc[8];
   logic [DW-1:0] sc_dat[8];
   bit            sc_last;
   logic [4:0]    sc_resp;
   logic [CW-1:0] sc_T;
   logic [AW-1:0] sc_addr;
   logic [3:0]    sc_snoop;
   logic [2:0]    sc_prot;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ace_aclk);
      #1;
      cyc_n++;
   endtask

   task automatic chk_idle_zero(input string pfx);
      chk({pfx, "_acvalid"}, LW'(acvalid), '0);
      chk({pfx, "_readies"}, LW'({crready, cdready}), '0);
      chk({pfx, "_busy_done"}, LW'({o_busy, o_done}), '0);
      chk({pfx, "_acpayload"}, LW'({acaddr, acsnoop, acprot}), '0);
      chk({pfx, "_results"}, LW'({o_crresp, o_latency, o_timeout_err, o_proto_err}), '0);
      chk({pfx, "_cdata"}, o_cdata, '0);
   endtask

   task automatic run_txn(input string tag);
      int need, ex, acc, last_cyc, e_lat, ac_bad, crc, dn, acx, done_c, start_c;
      bit tmo, cr_acc, e_proto;
      logic [LW-1:0] e_cdata;
      logic [4:0] e_resp;

      // Reference model: decide the exit cycle from the schedule, then results.
      last_cyc = (sc_last && sc_nb > 0) ? sc_cyc[sc_nb-1] : INF;
      if (sc_k == 0)       need = INF;
      else if (sc_resp[0]) need = (sc_k > last_cyc) ? sc_k : last_cyc;
      else                 need = sc_k;
      tmo = (sc_T != 0) && (need > int'(sc_T));
      ex  = tmo ? int'(sc_T) : need;
      acc = 0;
      e_cdata = '0;
      for (int i = 0; i < sc_nb; i++)
         if (sc_cyc[i] <= ex) begin
            if (acc < NB) e_cdata[acc*DW +: DW] = sc_dat[i];
            acc++;
         end
      cr_acc = (sc_k != 0) && (sc_k <= ex);
      if (tmo)             e_proto = (acc > NB);
      else if (sc_resp[0]) e_proto = (acc != NB) || !sc_last || (acc - 1 != NB - 1);
      else                 e_proto = (acc != 0);
      e_lat  = cr_acc ? sc_k : ex;
      e_resp = cr_acc ? sc_resp : 5'd0;

      // Request
      i_acaddr = sc_addr; i_acsnoop = sc_snoop; i_acprot = sc_prot; i_timeout = sc_T;
      i_start = 1'b1;
      start_c = cyc_n;
      step();
      i_start = 1'b0;

      // AC phase: payload must stay put while acready is low
      ac_bad = 0;
      for (int i = 0; i <= sc_acd; i++) begin
         if (acvalid !== 1'b1 || acaddr !== sc_addr || acsnoop !== sc_snoop || acprot !== sc_prot)
            ac_bad++;
         acready = (i == sc_acd);
         step();
      end
      acready = 1'b0;

      // RESP phase: responder plays the schedule; a stray i_start must be ignored
      crc = 0; dn = 0; acx = 0; done_c = -1;
      for (int r = 1; r <= ex + 3; r++) begin
         crvalid = (sc_k != 0) && (r == sc_k);
         crresp  = crvalid ? sc_resp : 5'($urandom);
         cdvalid = 1'b0; cdlast = 1'b0;
         cddata  = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < sc_nb; i++)
            if (sc_cyc[i] == r) begin
               cdvalid = 1'b1;
               cddata  = sc_dat[i];
               cdlast  = sc_last && (i == sc_nb - 1);
            end
         i_start  = (r == 2);
         i_acaddr = (r == 2) ? ~sc_addr : sc_addr;
         if (crready) crc++;
         if (acvalid) acx++;
         if (o_done) begin dn++; done_c = cyc_n; end
         step();
      end
      crvalid = 1'b0; cdvalid = 1'b0; cdlast = 1'b0; i_start = 1'b0;

      chk({tag, "_ac_hold"}, LW'(ac_bad), '0);
      chk({tag, "_ac_single"}, LW'(acx), '0);
      chk({tag, "_acaddr_kept"}, LW'(acaddr), LW'(sc_addr));
      chk({tag, "_done_count"}, LW'(dn), LW'(1));
      chk({tag, "_start_to_done"}, LW'(done_c - start_c), LW'(sc_acd + ex + 3));
      chk({tag, "_crready_cycles"}, LW'(crc), LW'(e_lat));
      chk({tag, "_latency"}, LW'(o_latency), LW'(e_lat));
      chk({tag, "_crresp"}, LW'(o_crresp), LW'(e_resp));
      chk({tag, "_cdata"}, o_cdata, e_cdata);
      chk({tag, "_timeout_err"}, LW'(o_timeout_err), LW'(tmo));
      chk({tag, "_proto_err"}, LW'(o_proto_err), LW'(e_proto));
      chk({tag, "_quiet_after"}, LW'({crready, cdready, o_busy}), '0);
   endtask

   task automatic set_base(input logic [AW-1:0] a, input logic [3:0] s);
      sc_addr = a; sc_snoop = s; sc_prot = 3'b010; sc_acd = 0; sc_T = '0;
      sc_k = 1; sc_nb = 0; sc_last = 1'b0; sc_resp = 5'b00000;
   endtask

   task automatic random_txn(input int n);
      int m, s;
      sc_addr  = {12'($urandom), $urandom};
      sc_snoop = 4'($urandom);
      sc_prot  = 3'($urandom);
      sc_acd   = $urandom_range(0, 4);
      sc_resp  = {4'($urandom), 1'($urandom)};
      sc_k     = $urandom_range(1, 10);
      sc_T     = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(1, 25)) : '0;
      for (int i = 0; i < 8; i++) sc_dat[i] = {$urandom, $urandom, $urandom, $urandom};
      if (sc_resp[0]) begin
         m = $urandom_range(0, 9);
         sc_nb   = (m == 6) ? 3 : (m == 7) ? 5 : 4;
         sc_last = (m != 8);
         s = $urandom_range(1, 6);
         for (int i = 0; i < sc_nb; i++) begin
            sc_cyc[i] = s;
            s = s + 1 + $urandom_range(0, 1);
         end
         if (m == 8) sc_T = CW'($urandom_range(5, 25));
         if (m == 9) sc_k = sc_cyc[sc_nb-1];
      end else begin
         sc_nb     = ($urandom_range(0, 3) == 0) ? 1 : 0;
         sc_last   = 1'b1;
         sc_cyc[0] = $urandom_range(1, sc_k);
      end
      run_txn($sformatf("rnd%0d", n));
   endtask

   initial begin
      #2;
      chk_idle_zero("reset");
      #10 ace_aresetn = 1'b1;
      step(); step();

      // 1: ReadShared, CR three cycles after the AC handshake
      set_base(44'h1000, 4'b0001);
      sc_k = 3;
      run_txn("t1_readshared");

      // 2: ReadUnique with a full line
      set_base(44'h2040, 4'b0111);
      sc_resp = 5'b00101; sc_k = 2; sc_nb = 4; sc_last = 1'b1;
      for (int i = 0; i < 4; i++) begin sc_cyc[i] = i + 1; sc_dat[i] = DW'(10 + i); end
      run_txn("t2_readunique");

      // 3: acready held low for 10 cycles
      set_base(44'h3080, 4'b0001);
      sc_acd = 10; sc_k = 2;
      run_txn("t3_ac_stall");

      // 4: no CR at all, timeout after 20 RESP cycles
      set_base(44'h40c0, 4'b0001);
      sc_k = 0; sc_T = 16'd20;
      run_txn("t4_timeout");

      // 5a: data ahead of CR, last beat concurrent with CR
      set_base(44'h5000, 4'b0111);
      sc_resp = 5'b00001; sc_k = 5; sc_nb = 4; sc_last = 1'b1;
      sc_cyc[0] = 1; sc_cyc[1] = 2; sc_cyc[2] = 3; sc_cyc[3] = 5;
      for (int i = 0; i < 4; i++) sc_dat[i] = {$urandom, $urandom, $urandom, $urandom};
      run_txn("t5_concurrent_last");

      // 5b: cdlast on beat 2
      sc_nb = 3; sc_k = 4;
      run_txn("t5_early_last");

      // Minimum-latency path
      set_base(44'h6000, 4'b0001);
      run_txn("t_min_latency");

      // 6: reset in the middle of RESP, then a normal snoop
      set_base(44'h7000, 4'b0111);
      i_acaddr = sc_addr; i_acsnoop = sc_snoop; i_timeout = '0;
      i_start = 1'b1; step(); i_start = 1'b0;
      acready = 1'b1; step(); acready = 1'b0;
      step(); step();
      chk("t6_in_resp", LW'({o_busy, crready}), LW'(2'b11));
      ace_aresetn = 1'b0;
      #1;
      chk_idle_zero("t6_mid_reset");
      #2 ace_aresetn = 1'b1;
      step(); step();
      set_base(44'h7100, 4'b0001);
      sc_k = 2;
      run_txn("t6_after_reset");

      for (int n = 0; n < 40; n++) random_txn(n);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
